// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard unit: forwarding selects and
// the execute-interlock FSM states.
package hazard_pkg;

    // Forwarding mux selects for the E-stage operands
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Multi-cycle execute interlock states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/fwd_sel.sv
// One operand's forwarding select: compares the E-stage source against the
// M and W destinations, the younger (M) result taking priority.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              reg_write_m_i,
    input  logic              reg_write_w_i,
    output logic [1:0]        fwd_o
);

    // Priority mux: M beats W, register x0 never forwards
    always_comb begin
        if (reg_write_m_i && (rd_m_i != {REG_AW{1'b0}}) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != {REG_AW{1'b0}}) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_WB;
        end else begin
            fwd_o = FWD_NONE;
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Five-stage pipeline hazard unit with E-stage forwarding, load-use stall,
// branch flush and a multi-cycle execute interlock.
// Optional build macro HAZARD_PERF_EN enables saturating stall/flush
// performance counters; without it StallCount/FlushCount read as zero.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 3,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              PCSrcE,
    input  logic              ResultSrcEb0,
    input  logic              MulStartE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MulBusy,
    output logic [PERF_W-1:0] StallCount,
    output logic [PERF_W-1:0] FlushCount
);

    // Reload value: the start cycle plus cnt+1 BUSY cycles gives MUL_LAT total
    localparam logic [3:0] LAT_M2 = (MUL_LAT >= 2) ? 4'(MUL_LAT - 2) : 4'd0;
    localparam logic       MC_EN  = (MUL_LAT >= 2) ? 1'b1 : 1'b0;

    mc_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mul_stall_s;
    logic       lw_stall_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_a_s)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_b_s)
    );

    assign lw_stall_s = ResultSrcEb0 && (RdE != {REG_AW{1'b0}})
                        && ((Rs1D == RdE) || (Rs2D == RdE));

    // Interlock next-state: hold E while the op still has cycles left
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_stall_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (MulStartE && MC_EN) begin
                    mul_stall_s = 1'b1;
                    cnt_d       = LAT_M2;
                    state_d     = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    mul_stall_s = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                end else begin
                    // Op leaves E now; a new start is only accepted from IDLE
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Interlock state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode: reset forces a clean bubble, mulStall dominates others
    always_comb begin
        if (reset) begin
            ForwardAE = FWD_NONE;
            ForwardBE = FWD_NONE;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushM    = 1'b1;
            MulBusy   = 1'b0;
        end else begin
            ForwardAE = fwd_a_s;
            ForwardBE = fwd_b_s;
            StallF    = lw_stall_s || mul_stall_s;
            StallD    = lw_stall_s || mul_stall_s;
            StallE    = mul_stall_s;
            FlushM    = mul_stall_s;
            FlushE    = (lw_stall_s || PCSrcE) && !mul_stall_s;
            FlushD    = PCSrcE && !mul_stall_s;
            MulBusy   = (state_q == BUSY);
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [PERF_W-1:0] CNT_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] CNT_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    // Saturating counts of front-end stall cycles and E flush cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= {PERF_W{1'b0}};
            flush_cnt_q <= {PERF_W{1'b0}};
        end else begin
            if (StallF && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (FlushE && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = {PERF_W{1'b0}};
    assign FlushCount = {PERF_W{1'b0}};
`endif

endmodule
